// File: rtl/ic74xx_pkg.sv
// Shared constants and types for the 74xx glue-logic models.
// Combinational helpers only; no latency, no backpressure.
package ic74xx_pkg;

    localparam int IC74368_WIDTH    = 6;
    localparam int IC74368_G1_WIDTH = 4;

    // Bit 0 = group 1, bit 1 = group 2.
    typedef logic [1:0] grp_en_t;

    // Only a clean 0 enables; X or Z on an active-low enable reads as disabled.
    function automatic logic en_from_noe(input logic noe);
        en_from_noe = 1'b0;
        if (noe == 1'b0) begin
            en_from_noe = 1'b1;
        end
    endfunction

endpackage

// File: rtl/ic74368_tri_inv.sv
// One group of N inverting tri-state drivers sharing an active-low enable.
// Zero latency, no backpressure: outputs float whenever noe is not a clean 0.
module ic74368_tri_inv
    import ic74xx_pkg::*;
#(
    parameter int N = 4
) (
    input  logic              noe,
    input  logic [N-1:0]      a,
    output wire logic [N-1:0] y
);

    logic drive;

    always_comb begin
        drive = en_from_noe(noe);
    end

    assign y = drive ? ~a : {N{1'bz}};

endmodule

// File: rtl/ic74368_inv_buffer.sv
// 74LS368 hex inverting tri-state buffer, two enable groups; optional sticky err under IC74368_XCHECK_EN.
// Latency 0 (REGISTERED=0) or 1 cycle (REGISTERED=1); no backpressure, outputs float until armed.
module ic74368_inv_buffer
    import ic74xx_pkg::*;
#(
    parameter int WIDTH      = IC74368_WIDTH,
    parameter int G1_WIDTH   = IC74368_G1_WIDTH,
    parameter int REGISTERED = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  noe1,
    input  logic                  noe2,
    input  logic [WIDTH-1:0]      a,
    output wire logic [WIDTH-1:0] y,
    output logic [1:0]            oe_active
`ifdef IC74368_XCHECK_EN
    ,
    output logic                  err
`endif
);

    localparam int G2_WIDTH = WIDTH - G1_WIDTH;

    logic             armed_q, armed_d;
    grp_en_t          oe_active_q, oe_active_d;
    grp_en_t          grp_en;
    logic [WIDTH-1:0] a_eff;
    logic             noe1_eff, noe2_eff;
    logic             noe1_gated, noe2_gated;

    generate
        if (REGISTERED != 0) begin : g_reg
            logic [WIDTH-1:0] a_q, a_d;
            logic             noe1_q, noe1_d;
            logic             noe2_q, noe2_d;

            always_comb begin
                a_d    = a;
                noe1_d = noe1;
                noe2_d = noe2;
            end

            // Reset parks both groups disabled so outputs float at the reset edge itself.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_q    <= '0;
                    noe1_q <= 1'b1;
                    noe2_q <= 1'b1;
                end else begin
                    a_q    <= a_d;
                    noe1_q <= noe1_d;
                    noe2_q <= noe2_d;
                end
            end

            assign a_eff    = a_q;
            assign noe1_eff = noe1_q;
            assign noe2_eff = noe2_q;
        end else begin : g_comb
            assign a_eff    = a;
            assign noe1_eff = noe1;
            assign noe2_eff = noe2;
        end
    endgenerate

    // An unknown enable stays unknown through the OR and is then rejected by en_from_noe.
    always_comb begin
        noe1_gated  = noe1_eff | ~armed_q;
        noe2_gated  = noe2_eff | ~armed_q;
        grp_en      = {en_from_noe(noe2_gated), en_from_noe(noe1_gated)};
        armed_d     = 1'b1;
        oe_active_d = grp_en;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            armed_q     <= 1'b0;
            oe_active_q <= '0;
        end else begin
            armed_q     <= armed_d;
            oe_active_q <= oe_active_d;
        end
    end

    assign oe_active = oe_active_q;

    ic74368_tri_inv #(.N(G1_WIDTH)) u_grp1 (
        .noe (noe1_gated),
        .a   (a_eff[G1_WIDTH-1:0]),
        .y   (y[G1_WIDTH-1:0])
    );

    ic74368_tri_inv #(.N(G2_WIDTH)) u_grp2 (
        .noe (noe2_gated),
        .a   (a_eff[WIDTH-1:G1_WIDTH]),
        .y   (y[WIDTH-1:G1_WIDTH])
    );

`ifdef IC74368_XCHECK_EN
    logic             err_q, err_d;
    logic [WIDTH-1:0] chk_mask;

    // Masking with 0 hides unknowns on disabled channels; enabled ones pass X through.
    always_comb begin
        chk_mask = '0;
        if (grp_en[0]) chk_mask[G1_WIDTH-1:0] = '1;
        if (grp_en[1]) chk_mask[WIDTH-1:G1_WIDTH] = '1;
        err_d = err_q;
        if ($isunknown(a_eff & chk_mask) || $isunknown({noe1_eff, noe2_eff})) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_ic74368_inv_buffer.sv
// Directed bench: combinational and registered instances driven by the same stimulus.
// Table vectors for steady-state behaviour, hand sequences for reset and latency corners.
module tb_ic74368_inv_buffer;

    typedef struct packed {
        logic       noe1;
        logic       noe2;
        logic [5:0] a;
        logic [5:0] ev;
        logic [5:0] ez;
        logic [1:0] eo;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       noe1;
    logic       noe2;
    logic [5:0] a;
    wire  [5:0] y_c;
    wire  [5:0] y_r;
    logic [1:0] oe_c;
    logic [1:0] oe_r;
    logic [5:0] yc_z;
    logic [5:0] yr_z;
`ifdef IC74368_XCHECK_EN
    logic       err_c;
    logic       err_r;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ic74368_inv_buffer #(.WIDTH(6), .G1_WIDTH(4), .REGISTERED(0)) u_dut_c (
        .clk       (clk),
        .rst_n     (rst_n),
        .noe1      (noe1),
        .noe2      (noe2),
        .a         (a),
        .y         (y_c),
        .oe_active (oe_c)
`ifdef IC74368_XCHECK_EN
        ,
        .err       (err_c)
`endif
    );

    ic74368_inv_buffer #(.WIDTH(6), .G1_WIDTH(4), .REGISTERED(1)) u_dut_r (
        .clk       (clk),
        .rst_n     (rst_n),
        .noe1      (noe1),
        .noe2      (noe2),
        .a         (a),
        .y         (y_r),
        .oe_active (oe_r)
`ifdef IC74368_XCHECK_EN
        ,
        .err       (err_r)
`endif
    );

    for (genvar i = 0; i < 6; i++) begin : g_zdet
        assign yc_z[i] = (y_c[i] === 1'bz);
        assign yr_z[i] = (y_r[i] === 1'bz);
    end

    task automatic chk_y(input string nm, input logic [5:0] got, input logic [5:0] gz,
                         input logic [5:0] ev, input logic [5:0] ez);
        n_cmp++;
        if (gz !== ez || (got & ~ez) !== (ev & ~ez)) begin
            n_bad++;
            $display("FAIL %s: got y=%h zmask=%h, want y=%h zmask=%h",
                     nm, got & ~gz, gz, ev & ~ez, ez);
        end
    endtask

    task automatic chk_v(input string nm, input logic [1:0] got, input logic [1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b", nm, got, exp);
        end
    endtask

    vec_t vecs [10];
    vec_t v;
    vec_t prev;

    initial begin
        vecs[0] = '{1'b1, 1'b0, 6'h00, 6'h30, 6'h0F, 2'b10};
        vecs[1] = '{1'b0, 1'b0, 6'h00, 6'h3F, 6'h00, 2'b11};
        vecs[2] = '{1'b0, 1'b0, 6'h0F, 6'h30, 6'h00, 2'b11};
        vecs[3] = '{1'b0, 1'b1, 6'h30, 6'h0F, 6'h30, 2'b01};
        vecs[4] = '{1'b1, 1'b1, 6'h2A, 6'h00, 6'h3F, 2'b00};
        vecs[5] = '{1'b0, 1'b0, 6'h15, 6'h2A, 6'h00, 2'b11};
        vecs[6] = '{1'b0, 1'b0, 6'h00, 6'h3F, 6'h00, 2'b11};
        vecs[7] = '{1'b0, 1'b0, 6'h3F, 6'h00, 6'h00, 2'b11};
        vecs[8] = '{1'b1, 1'b0, 6'h3C, 6'h00, 6'h0F, 2'b10};
        vecs[9] = '{1'b0, 1'b1, 6'h05, 6'h0A, 6'h30, 2'b01};

        rst_n = 1'b0;
        noe1  = 1'b0;
        noe2  = 1'b0;
        a     = 6'h00;

        repeat (2) @(posedge clk);
        #1;
        chk_y("reset y_c", y_c, yc_z, 6'h00, 6'h3F);
        chk_y("reset y_r", y_r, yr_z, 6'h00, 6'h3F);
        chk_v("reset oe_c", oe_c, 2'b00);
        chk_v("reset oe_r", oe_r, 2'b00);

        rst_n = 1'b1;
        @(negedge clk);
        chk_y("prearm y_c", y_c, yc_z, 6'h00, 6'h3F);
        @(posedge clk);
        #1;
        chk_y("arm y_c", y_c, yc_z, 6'h3F, 6'h00);
        chk_y("arm y_r", y_r, yr_z, 6'h3F, 6'h00);
        chk_v("arm oe_c", oe_c, 2'b00);
        @(posedge clk);
        #1;
        chk_v("arm+1 oe_c", oe_c, 2'b11);
        chk_v("arm+1 oe_r", oe_r, 2'b11);

        prev = '{1'b0, 1'b0, 6'h00, 6'h3F, 6'h00, 2'b11};
        for (int i = 0; i < 10; i++) begin
            v    = vecs[i];
            noe1 = v.noe1;
            noe2 = v.noe2;
            a    = v.a;
            @(negedge clk);
            chk_y($sformatf("v%0d y_c", i), y_c, yc_z, v.ev, v.ez);
            chk_y($sformatf("v%0d y_r hold", i), y_r, yr_z, prev.ev, prev.ez);
            @(posedge clk);
            #1;
            chk_y($sformatf("v%0d y_r", i), y_r, yr_z, v.ev, v.ez);
            chk_v($sformatf("v%0d oe_c", i), oe_c, v.eo);
            prev = v;
        end

        noe1  = 1'b0;
        noe2  = 1'b0;
        a     = 6'h12;
        rst_n = 1'b0;
        @(negedge clk);
        chk_y("midrst pre y_c", y_c, yc_z, 6'h2D, 6'h00);
        chk_y("midrst pre y_r", y_r, yr_z, prev.ev, prev.ez);
        @(posedge clk);
        #1;
        chk_y("midrst y_c", y_c, yc_z, 6'h00, 6'h3F);
        chk_y("midrst y_r", y_r, yr_z, 6'h00, 6'h3F);
        chk_v("midrst oe_c", oe_c, 2'b00);
        chk_v("midrst oe_r", oe_r, 2'b00);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_y("rearm y_c", y_c, yc_z, 6'h2D, 6'h00);
        chk_y("rearm y_r", y_r, yr_z, 6'h2D, 6'h00);

`ifdef IC74368_XCHECK_EN
        chk_v("err clean", {1'b0, err_c}, 2'b00);
        a    = 6'h00;
        a[0] = 1'bx;
        @(posedge clk);
        #1;
        chk_v("err set", {1'b0, err_c}, 2'b01);
        a = 6'h00;
        repeat (2) @(posedge clk);
        #1;
        chk_v("err sticky", {1'b0, err_c}, 2'b01);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk_v("err cleared", {1'b0, err_c}, 2'b00);
        rst_n = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
